hex_dump_formatter: RTL and testbench

HEX_DUMP_FORMATTER -- requirements
Module: hex_dump_formatter

---
 rtl/hex_dump_pkg.sv | 28 ++
 rtl/hex_dump_formatter.sv | 116 +++++++++++
 tb/tb_hex_dump_formatter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_dump_pkg.sv
// Shared encoding and ASCII helpers for the hex dump formatter.
// HEX_DUMP_LINE_INDEX_EN adds the line-index prefix states.
package hex_dump_pkg;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef enum logic [3:0] {
    IDLE,
`ifdef HEX_DUMP_LINE_INDEX_EN
    PFX_HI,
    PFX_LO,
    PFX_COLON,
`endif
    HEX_HI,
    HEX_LO,
    SEP,
    CR,
    LF
  } state_e;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/hex_dump_formatter.sv
// Turns a raw byte stream into uppercase hex text lines for a UART.
// Define HEX_DUMP_LINE_INDEX_EN to prefix every line with "NN:".
module hex_dump_formatter
  import hex_dump_pkg::*;
#(
  parameter int BYTES_PER_LINE = 4
) (
  input  logic       comm_clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CNT_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

  state_e           state, state_nxt;
  logic [7:0]       byte_q;
  logic             last_q;
  logic [CNT_W-1:0] byte_cnt;
  logic             accept, out_hs, line_end;
`ifdef HEX_DUMP_LINE_INDEX_EN
  logic [7:0]       line_idx;
`endif

  // Gating on reset keeps in_ready and out_valid low during the reset cycle itself.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state != IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign line_end  = last_q || (byte_cnt == CNT_W'(BYTES_PER_LINE - 1));

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state    <= IDLE;
      byte_q   <= 8'h00;
      last_q   <= 1'b0;
      byte_cnt <= '0;
`ifdef HEX_DUMP_LINE_INDEX_EN
      line_idx <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        byte_q <= in_data;
        last_q <= in_last;
      end
      if (out_hs && state == SEP)
        byte_cnt <= byte_cnt + 1'b1;
      if (out_hs && state == LF) begin
        byte_cnt <= '0;
`ifdef HEX_DUMP_LINE_INDEX_EN
        // End of dump restarts numbering; otherwise wrap naturally at 8 bits.
        line_idx <= last_q ? 8'h00 : line_idx + 8'h01;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    out_data  = 8'h00;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef HEX_DUMP_LINE_INDEX_EN
          state_nxt = (byte_cnt == '0) ? PFX_HI : HEX_HI;
`else
          state_nxt = HEX_HI;
`endif
        end
      end
`ifdef HEX_DUMP_LINE_INDEX_EN
      PFX_HI: begin
        out_data = nib2ascii(line_idx[7:4]);
        if (out_hs) state_nxt = PFX_LO;
      end
      PFX_LO: begin
        out_data = nib2ascii(line_idx[3:0]);
        if (out_hs) state_nxt = PFX_COLON;
      end
      PFX_COLON: begin
        out_data = ASCII_COLON;
        if (out_hs) state_nxt = HEX_HI;
      end
`endif
      HEX_HI: begin
        out_data = nib2ascii(byte_q[7:4]);
        if (out_hs) state_nxt = HEX_LO;
      end
      HEX_LO: begin
        out_data = nib2ascii(byte_q[3:0]);
        if (out_hs) state_nxt = line_end ? CR : SEP;
      end
      SEP: begin
        out_data = ASCII_SP;
        if (out_hs) state_nxt = IDLE;
      end
      CR: begin
        out_data = ASCII_CR;
        if (out_hs) state_nxt = LF;
      end
      LF: begin
        out_data = ASCII_LF;
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) out_data = 8'h00;
  end

endmodule

// File: tb/tb_hex_dump_formatter.sv
// Scoreboard bench for hex_dump_formatter; honours HEX_DUMP_LINE_INDEX_EN.
module tb_hex_dump_formatter;

  localparam int BPL = 4;
`ifdef HEX_DUMP_LINE_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic       comm_clock = 1'b0;
  logic       reset, in_valid, in_last, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;

  int         n_vec = 0, n_err = 0, n_out = 0, n_acc = 0, m_cnt = 0;
  logic [7:0] m_idx = 8'h00;
  logic [7:0] sb[$];
  logic [7:0] log_q[$];

  hex_dump_formatter #(.BYTES_PER_LINE(BPL)) dut (
    .comm_clock(comm_clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 comm_clock = ~comm_clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'd48 + {4'h0, n} : 8'd55 + {4'h0, n};
  endfunction

  // Expected text for one accepted byte, straight from the line format rules.
  task automatic exp_byte(input logic [7:0] b, input logic last);
    if (IDX_EN && m_cnt == 0) begin
      sb.push_back(hx(m_idx[7:4]));
      sb.push_back(hx(m_idx[3:0]));
      sb.push_back(8'h3A);
    end
    sb.push_back(hx(b[7:4]));
    sb.push_back(hx(b[3:0]));
    if (last || m_cnt == BPL - 1) begin
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
      m_cnt = 0;
      m_idx = last ? 8'h00 : m_idx + 8'h01;
    end else begin
      sb.push_back(8'h20);
      m_cnt++;
    end
  endtask

  always @(negedge comm_clock) begin
    if (reset) begin
      sb.delete();
      m_cnt = 0;
      m_idx = 8'h00;
    end else begin
      if (in_valid && in_ready) begin
        exp_byte(in_data, in_last);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        log_q.push_back(out_data);
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else                chk("char", {24'h0, out_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    @(posedge comm_clock); #1;
    in_valid = 1'b1; in_data = b; in_last = last;
    for (int k = 0; k < 1000; k++) begin
      @(negedge comm_clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", in_ready, 1);
    @(posedge comm_clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000; k++) begin
      @(negedge comm_clock);
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_ov", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, L, L2, acc0, idx;
    logic [7:0] d0;
    logic [7:0] data [12];

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    @(negedge comm_clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge comm_clock); #1 reset = 1'b0;
    @(negedge comm_clock);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_data", out_data, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // DE AD BE EF as one full line, one-cycle latency on the first byte
    n0 = n_out;
    send(8'hDE, 1'b0);
    @(negedge comm_clock);
    chk("latency", out_valid, 1);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b1);
    drain();
    chk("line1_len", n_out - n0, IDX_EN ? 16 : 13);

    // 00..04 with last on 04, then numbering restarts
    L = log_q.size();
    for (int i = 0; i < 5; i++) send(8'(i), i == 4);
    drain();
    chk("five_len", log_q.size() - L, IDX_EN ? 23 : 17);
    L2 = log_q.size();
    send(8'h77, 1'b1);
    drain();
    chk("restart_c0", log_q[L2], IDX_EN ? 8'h30 : 8'h37);
    chk("restart_c2", log_q[L2+2], IDX_EN ? 8'h3A : 8'h0D);

    // out_ready stall mid-line
    send(8'h5A, 1'b0);
    @(posedge comm_clock); #1 out_ready = 1'b0;
    @(negedge comm_clock);
    d0 = out_data;
    chk("stall_vld0", out_valid, 1);
    repeat (10) begin
      @(negedge comm_clock);
      chk("stall_data", out_data, d0);
      chk("stall_vld", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge comm_clock); #1 out_ready = 1'b1;
    send(8'h5B, 1'b1);
    drain();

    // reset after "A5" is out, before the separator
    n0 = n_out;
    send(8'hA5, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(posedge comm_clock); #1;
      if (n_out >= n0 + (IDX_EN ? 5 : 2)) break;
    end
    chk("a5_chars", n_out - n0, IDX_EN ? 5 : 2);
    out_ready = 1'b0; reset = 1'b1;
    @(negedge comm_clock);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge comm_clock); #1 reset = 1'b0; out_ready = 1'b1;
    n0 = n_out;
    repeat (5) begin
      @(negedge comm_clock);
      chk("midrst_idle_ov", out_valid, 0);
    end
    chk("midrst_no_chars", n_out, n0);
    L = log_q.size();
    send(8'h3C, 1'b1);
    drain();
    chk("post_rst_c0", log_q[L], IDX_EN ? 8'h30 : 8'h33);
    chk("post_rst_len", n_out - n0, IDX_EN ? 7 : 4);

    // continuous in_valid with random backpressure
    for (int i = 0; i < 12; i++) data[i] = 8'($urandom_range(0, 255));
    acc0 = n_acc;
    idx = 0;
    @(posedge comm_clock); #1;
    in_valid = 1'b1; in_data = data[0]; in_last = 1'b0;
    for (int cyc = 0; cyc < 2000 && idx < 12; cyc++) begin
      bit acc;
      @(negedge comm_clock);
      acc = in_ready;
      @(posedge comm_clock); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        idx++;
        if (idx < 12) begin
          in_data = data[idx];
          in_last = (idx == 11);
        end else begin
          in_valid = 1'b0;
          in_last = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    chk("stream_sent", idx, 12);
    drain();
    chk("stream_accepted", n_acc - acc0, 12);

`ifdef HEX_DUMP_LINE_INDEX_EN
    // 256 full lines, then line index wraps to 00
    L = 0; L2 = 0;
    for (int ln = 0; ln < 257; ln++) begin
      if (ln == 255 || ln == 256) begin
        drain();
        if (ln == 255) L = log_q.size();
        else           L2 = log_q.size();
      end
      if (ln == 256) send(8'hC3, 1'b1);
      else for (int b = 0; b < BPL; b++) send(8'(ln ^ (b << 4)), 1'b0);
    end
    drain();
    chk("wrap_ff_0", log_q[L], 8'h46);
    chk("wrap_ff_1", log_q[L+1], 8'h46);
    chk("wrap_ff_2", log_q[L+2], 8'h3A);
    chk("wrap_00_0", log_q[L2], 8'h30);
    chk("wrap_00_1", log_q[L2+1], 8'h30);
    chk("wrap_00_2", log_q[L2+2], 8'h3A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
